des_decrypt_core: RTL and testbench

DES_DECRYPT_CORE -- requirements
Module: des_decrypt_core

---
 rtl/des_decrypt_core.sv | 202 ++++++++++++++++++++
 tb/tb_des_decrypt_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/des_decrypt_core.sv
// Iterative DES decryption engine: one Feistel round per clock, 16 rounds per block.
// FIPS bit 1 is the MSB of every vector; all tables use FIPS 1-based bit numbers.
module des_decrypt_core (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [63:0] ciphertext_i,
    input  logic [63:0] key_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [63:0] plaintext_o,
    output logic        busy_o
);
    // state | meaning
    // IDLE  | waiting for a ciphertext/key pair
    // ROUND | running rounds 1..16, round_cnt = rounds already completed
    // DONE  | plaintext_o valid, waiting for out_ready_i
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2,  60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6,  64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1,  59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5,  63, 55, 47, 39, 31, 23, 15, 7};

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32,  39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30,  37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28,  35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26,  33, 1, 41,  9, 49, 17, 57, 25};

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,   4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,  12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,  20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,  28, 29, 30, 31, 32,  1};

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,   1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,  19, 13, 30,  6, 22, 11,  4, 25};

    // Parity bits 8,16,...,64 never appear here, so they are dropped.
    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,   1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,  19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,   7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,  21, 13,  5, 28, 20, 12,  4};

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,   3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,  16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,  30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,  46, 42, 50, 36, 29, 32};

    // Indexed as box*64 + row*16 + col.
    localparam int SBOX_T [512] = '{
        14,  4, 13,  1,  2, 15, 11,  8,  3, 10,  6, 12,  5,  9,  0,  7,
         0, 15,  7,  4, 14,  2, 13,  1, 10,  6, 12, 11,  9,  5,  3,  8,
         4,  1, 14,  8, 13,  6,  2, 11, 15, 12,  9,  7,  3, 10,  5,  0,
        15, 12,  8,  2,  4,  9,  1,  7,  5, 11,  3, 14, 10,  0,  6, 13,
        15,  1,  8, 14,  6, 11,  3,  4,  9,  7,  2, 13, 12,  0,  5, 10,
         3, 13,  4,  7, 15,  2,  8, 14, 12,  0,  1, 10,  6,  9, 11,  5,
         0, 14,  7, 11, 10,  4, 13,  1,  5,  8, 12,  6,  9,  3,  2, 15,
        13,  8, 10,  1,  3, 15,  4,  2, 11,  6,  7, 12,  0,  5, 14,  9,
        10,  0,  9, 14,  6,  3, 15,  5,  1, 13, 12,  7, 11,  4,  2,  8,
        13,  7,  0,  9,  3,  4,  6, 10,  2,  8,  5, 14, 12, 11, 15,  1,
        13,  6,  4,  9,  8, 15,  3,  0, 11,  1,  2, 12,  5, 10, 14,  7,
         1, 10, 13,  0,  6,  9,  8,  7,  4, 15, 14,  3, 11,  5,  2, 12,
         7, 13, 14,  3,  0,  6,  9, 10,  1,  2,  8,  5, 11, 12,  4, 15,
        13,  8, 11,  5,  6, 15,  0,  3,  4,  7,  2, 12,  1, 10, 14,  9,
        10,  6,  9,  0, 12, 11,  7, 13, 15,  1,  3, 14,  5,  2,  8,  4,
         3, 15,  0,  6, 10,  1, 13,  8,  9,  4,  5, 11, 12,  7,  2, 14,
         2, 12,  4,  1,  7, 10, 11,  6,  8,  5,  3, 15, 13,  0, 14,  9,
        14, 11,  2, 12,  4,  7, 13,  1,  5,  0, 15, 10,  3,  9,  8,  6,
         4,  2,  1, 11, 10, 13,  7,  8, 15,  9, 12,  5,  6,  3,  0, 14,
        11,  8, 12,  7,  1, 14,  2, 13,  6, 15,  0,  9, 10,  4,  5,  3,
        12,  1, 10, 15,  9,  2,  6,  8,  0, 13,  3,  4, 14,  7,  5, 11,
        10, 15,  4,  2,  7, 12,  9,  5,  6,  1, 13, 14,  0, 11,  3,  8,
         9, 14, 15,  5,  2,  8, 12,  3,  7,  0,  4, 10,  1, 13, 11,  6,
         4,  3,  2, 12,  9,  5, 15, 10, 11, 14,  1,  7,  6,  0,  8, 13,
         4, 11,  2, 14, 15,  0,  8, 13,  3, 12,  9,  7,  5, 10,  6,  1,
        13,  0, 11,  7,  4,  9,  1, 10, 14,  3,  5, 12,  2, 15,  8,  6,
         1,  4, 11, 13, 12,  3,  7, 14, 10, 15,  6,  8,  0,  5,  9,  2,
         6, 11, 13,  8,  1,  4, 10,  7,  9,  5,  0, 15, 14,  2,  3, 12,
        13,  2,  8,  4,  6, 15, 11,  1, 10,  9,  3, 14,  5,  0, 12,  7,
         1, 15, 13,  8, 10,  3,  7,  4, 12,  5,  6, 11,  0, 14,  9,  2,
         7, 11,  4,  1,  9, 12, 14,  2,  0,  6, 10, 13, 15,  3,  5,  8,
         2,  1, 14,  7,  4, 10,  8, 13, 15, 12,  9,  0,  3,  5,  6, 11};

    function automatic logic [63:0] ip_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] fp_perm(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] pc1_perm(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] pc2_perm(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] k);
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  six;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int b = 0; b < 8; b++) begin
            six = x[47-6*b -: 6];
            s[31-4*b -: 4] = 4'(SBOX_T[b*64 + int'({six[5], six[0], six[4:1]})]);
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    state_t      state;
    logic [3:0]  round_cnt;
    logic [31:0] l_reg, r_reg;
    logic [27:0] c_reg, d_reg;

    logic [63:0] ip_val;
    logic [55:0] pc1_val;
    logic [31:0] r_next;

    assign ip_val  = ip_perm(ciphertext_i);
    assign pc1_val = pc1_perm(key_i);
    assign r_next  = l_reg ^ feistel(r_reg, pc2_perm({c_reg, d_reg}));

    assign in_ready_o = (state == IDLE);
    assign busy_o     = (state != IDLE);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            round_cnt   <= 4'd0;
            l_reg       <= 32'd0;
            r_reg       <= 32'd0;
            c_reg       <= 28'd0;
            d_reg       <= 28'd0;
            plaintext_o <= 64'd0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid_i) begin
                        l_reg     <= ip_val[63:32];
                        r_reg     <= ip_val[31:0];
                        c_reg     <= pc1_val[55:28];
                        d_reg     <= pc1_val[27:0];
                        round_cnt <= 4'd0;
                        state     <= ROUND;
                    end
                end
                ROUND: begin
                    l_reg <= r_reg;
                    r_reg <= r_next;
                    // Right rotation walks the encryption schedule backwards.
                    case (round_cnt)
                        4'd0, 4'd7, 4'd14: begin
                            c_reg <= {c_reg[0], c_reg[27:1]};
                            d_reg <= {d_reg[0], d_reg[27:1]};
                        end
                        4'd15: begin
                        end
                        default: begin
                            c_reg <= {c_reg[1:0], c_reg[27:2]};
                            d_reg <= {d_reg[1:0], d_reg[27:2]};
                        end
                    endcase
                    if (round_cnt == 4'd15) begin
                        plaintext_o <= fp_perm({r_next, r_reg});
                        out_valid_o <= 1'b1;
                        state       <= DONE;
                    end else begin
                        round_cnt <= round_cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready_i) begin
                        out_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_des_decrypt_core.sv
// Directed bench for des_decrypt_core using published DES known-answer vectors.
module tb_des_decrypt_core;
    localparam logic [63:0] KA = 64'h133457799BBCDFF1;
    localparam logic [63:0] CA = 64'h85E813540F0AB405;
    localparam logic [63:0] PA = 64'h0123456789ABCDEF;
    localparam logic [63:0] KB = 64'h0E329232EA6D0D73;
    localparam logic [63:0] CB = 64'h0000000000000000;
    localparam logic [63:0] PB = 64'h8787878787878787;
    localparam logic [63:0] KC = 64'h0000000000000000;
    localparam logic [63:0] KD = 64'h0101010101010101;
    localparam logic [63:0] CC = 64'h8CA64DE9C1B123A7;
    localparam logic [63:0] PC = 64'h0000000000000000;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] ciphertext;
    logic [63:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] plaintext;
    logic        busy;

    int          n_checks;
    int          n_pass;
    int          n_fail;
    int          lat;
    int          seen;
    int          cyc;
    int          gap;
    logic        will_acc;
    int          acc_t[$];
    logic [63:0] res[$];

    des_decrypt_core dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .ciphertext_i (ciphertext),
        .key_i        (key),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .plaintext_o  (plaintext),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] k, input logic [63:0] c);
        key        = k;
        ciphertext = c;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    // Counts edges after the accept edge until out_valid is seen (bounded).
    task automatic wait_valid(output int l);
        l = 0;
        while (!out_valid && l < 40) begin
            tick();
            l++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;

        // Reset with in_valid high: nothing may be accepted.
        rst_n      = 1'b0;
        in_valid   = 1'b1;
        key        = KA;
        ciphertext = CA;
        out_ready  = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_plaintext", plaintext, 0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("idle_after_rst", busy, 0);

        // Vector A: latency, result, then backpressure.
        accept(KA, CA);
        check("a_busy", busy, 1);
        check("a_in_ready", in_ready, 0);
        wait_valid(lat);
        check("a_latency", lat, 16);
        check("a_plaintext", plaintext, PA);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_plaintext", plaintext, PA);
            check("bp_in_ready", in_ready, 0);
            check("bp_out_valid", out_valid, 1);
        end
        handshake();
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);
        check("hs_retain", plaintext, PA);

        // Vector B with in_valid and scrambled inputs held during rounds and DONE.
        accept(KB, CB);
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid   = 1'b1;
            key        = {$urandom, $urandom};
            ciphertext = {$urandom, $urandom};
            tick();
            lat++;
        end
        check("b_latency", lat, 16);
        tick();
        tick();
        in_valid = 1'b0;
        check("b_done_hold", out_valid, 1);
        check("b_plaintext", plaintext, PB);
        handshake();
        check("b_idle", in_ready, 1);

        // Abort at round 8.
        accept(KA, CA);
        repeat (8) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_out_valid", out_valid, 0);
        check("abort_plaintext", plaintext, 0);
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_valid", seen, 0);

        accept(KA, CA);
        wait_valid(lat);
        check("a2_latency", lat, 16);
        check("a2_plaintext", plaintext, PA);
        handshake();

        // Parity bits must not matter: KD and KC give the same result.
        accept(KD, CC);
        wait_valid(lat);
        check("d_latency", lat, 16);
        check("d_plaintext", plaintext, PC);
        handshake();
        accept(KC, CC);
        wait_valid(lat);
        check("c_latency", lat, 16);
        check("c_plaintext", plaintext, PC);
        handshake();

        // Back-to-back with in_valid held and out_ready high.
        acc_t.delete();
        res.delete();
        cyc        = 0;
        out_ready  = 1'b1;
        in_valid   = 1'b1;
        key        = KA;
        ciphertext = CA;
        while (res.size() < 2 && cyc < 80) begin
            will_acc = in_ready && in_valid;
            tick();
            cyc++;
            if (will_acc) begin
                acc_t.push_back(cyc);
                if (acc_t.size() == 1) begin
                    key        = KB;
                    ciphertext = CB;
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid) res.push_back(plaintext);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("b2b_accepts", acc_t.size(), 2);
        gap = (acc_t.size() >= 2) ? acc_t[1] - acc_t[0] : -1;
        check("b2b_gap", gap, 18);
        check("b2b_results", res.size(), 2);
        check("b2b_first", (res.size() >= 1) ? res[0] : 64'hX, PA);
        check("b2b_second", (res.size() >= 2) ? res[1] : 64'hX, PB);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
